// File: rtl/vga_mem_viewer_if.sv
// vga_mem_viewer_if: pixel-fetch bus between the viewer and its memory/overlay sources
interface vga_mem_viewer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_LAYERS = 2
);
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic [DATA_WIDTH-1:0] pixel_in;
  logic [NUM_LAYERS-1:0] layer_req;
  logic [8*NUM_LAYERS-1:0] layer_rgb;
  modport master (output pixel_x, pixel_y, input pixel_in, layer_req, layer_rgb);
  modport slave (input pixel_x, pixel_y, output pixel_in, layer_req, layer_rgb);
endinterface

// File: rtl/vga_mem_viewer.sv
// vga_mem_viewer: VGA timing plus memory bit-grid, blinking cursor and overlay layer compositing
module vga_mem_viewer #(
  parameter int DATA_WIDTH = 16,
  parameter int BX = 3,
  parameter int BY = 3,
  parameter int VIEW_W = 512,
  parameter int VIEW_H = 384,
  parameter int NUM_LAYERS = 2,
  parameter int LAT = 1,
  parameter int H_ACT = 640,
  parameter int H_FP = 16,
  parameter int H_SW = 96,
  parameter int H_BP = 48,
  parameter int V_ACT = 480,
  parameter int V_FP = 10,
  parameter int V_SW = 2,
  parameter int V_BP = 33,
  parameter int BLINK_FRAMES = 30
) (
  input  logic CLK_50,
  input  logic RESET_N,
  input  logic [1:0] mode,
  input  logic cursor_en,
  input  logic [$clog2(VIEW_W>>BX)-1:0] cursor_x,
  input  logic [$clog2(VIEW_H>>BY)-1:0] cursor_y,
  vga_mem_viewer_if.master mem,
  output logic [2:0] RED,
  output logic [2:0] GREEN,
  output logic [1:0] BLUE,
  output logic h_sync,
  output logic v_sync,
  output logic frame_start
);
  localparam int DWB = $clog2(DATA_WIDTH);
  localparam int FCW = $clog2(BLINK_FRAMES + 1);
  localparam int CXW = $clog2(VIEW_W>>BX);
  localparam int CYW = $clog2(VIEW_H>>BY);
  localparam logic [9:0] H_LAST = 10'(H_ACT + H_FP + H_SW + H_BP - 1);
  localparam logic [9:0] V_LAST = 10'(V_ACT + V_FP + V_SW + V_BP - 1);
  logic [9:0] x, y, sx, sy;
  logic [9:0] px [LAT];
  logic [9:0] py [LAT];
  logic act_d [LAT];
  logic hs_d [LAT];
  logic vs_d [LAT];
  logic [FCW-1:0] fcnt;
  logic phase, on_bit, hit;
  logic [CXW-1:0] cx;
  logic [CYW-1:0] cy;
  logic [7:0] grid, lay, rgb_n, rgb_q;
  assign mem.pixel_x = x;
  assign mem.pixel_y = y;
  assign frame_start = RESET_N && x == '0 && y == '0;
  // stage 0 counters feed a LAT-deep delay line so the last stage lines up with fetched data
  always_ff @(posedge CLK_50 or negedge RESET_N)
    if (!RESET_N) begin
      x <= '0;
      y <= '0;
      for (int i = 0; i < LAT; i++) begin
        px[i] <= '0;
        py[i] <= '0;
        act_d[i] <= 1'b0;
        hs_d[i] <= 1'b1;
        vs_d[i] <= 1'b1;
      end
    end else begin
      x <= x == H_LAST ? '0 : x + 10'd1;
      if (x == H_LAST) y <= y == V_LAST ? '0 : y + 10'd1;
      px[0] <= x;
      py[0] <= y;
      act_d[0] <= x < 10'(H_ACT) && y < 10'(V_ACT);
      hs_d[0] <= !(x >= 10'(H_ACT + H_FP) && x < 10'(H_ACT + H_FP + H_SW));
      vs_d[0] <= !(y >= 10'(V_ACT + V_FP) && y < 10'(V_ACT + V_FP + V_SW));
      for (int i = 1; i < LAT; i++) begin
        px[i] <= px[i-1];
        py[i] <= py[i-1];
        act_d[i] <= act_d[i-1];
        hs_d[i] <= hs_d[i-1];
        vs_d[i] <= vs_d[i-1];
      end
    end
  always_ff @(posedge CLK_50 or negedge RESET_N)
    if (!RESET_N) begin
      fcnt <= '0;
      phase <= 1'b0;
      cx <= '0;
      cy <= '0;
    end else begin
      if (frame_start) begin
        cx <= cursor_x;
        cy <= cursor_y;
      end
      if (!cursor_en) begin
        fcnt <= '0;
        phase <= 1'b0;
      end else if (frame_start) begin
        fcnt <= fcnt == FCW'(BLINK_FRAMES - 1) ? '0 : fcnt + FCW'(1);
        if (fcnt == FCW'(BLINK_FRAMES - 1)) phase <= !phase;
      end
    end
  assign sx = px[LAT-1];
  assign sy = py[LAT-1];
  // inverting the cell index within a word selects MSB-first bit order
  assign on_bit = mem.pixel_in[~sx[BX +: DWB]];
  assign hit = cursor_en && phase && (sx >> BX) == 10'(cx) && (sy >> BY) == 10'(cy);
  always_comb begin
    grid = on_bit ? 8'hFF : 8'b001_001_01;
    if (mode == 2'd0) begin
      grid = ~|sx[BX-1:0] || ~|sy[BY-1:0] ? 8'b111_000_00 : grid;
      grid = ~|sx[BX+2:0] ? 8'b000_000_01 : grid;
      grid = ~|sx[BX+DWB-1:0] ? 8'b000_000_11 : grid;
    end
    grid = hit ? ~grid : grid;
    lay = 8'b000_001_00;
    for (int i = 0; i < NUM_LAYERS; i++) lay = mem.layer_req[i] ? mem.layer_rgb[8*i +: 8] : lay;
    rgb_n = !act_d[LAT-1] ? 8'h00
          : mode == 2'd2 ? 8'b111_000_00
          : mode == 2'd3 ? {{3{sx[9]}}, {3{sx[8]}}, {2{sx[7]}}}
          : sx < 10'(VIEW_W) && sy < 10'(VIEW_H) ? grid : lay;
  end
  always_ff @(posedge CLK_50 or negedge RESET_N)
    if (!RESET_N) begin
      rgb_q <= '0;
      h_sync <= 1'b1;
      v_sync <= 1'b1;
    end else begin
      rgb_q <= rgb_n;
      h_sync <= hs_d[LAT-1];
      v_sync <= vs_d[LAT-1];
    end
  assign {RED, GREEN, BLUE} = rgb_q;
endmodule
